// File: rtl/fibo_job_arbiter.sv
// fibo_job_arbiter
//   Shares one Fibonacci engine among NUM_REQ requesters. A round-robin
//   arbiter picks a job, and a small FSM runs it on the engine:
//   CLEAR (one cycle) -> RUN (hold start until done or timeout) -> RESP.
//   Indices 0 and 1 are answered locally without touching the engine.
//
// Optional feature (macro FIBO_LAST_RESULT_CACHE_EN):
//   A one-entry cache of the last successful engine job (index, data).
//   A granted index >= 2 that hits the cache is answered IDLE -> RESP.
//   Without the macro, no cache storage exists.
//
// Ports
//   clk, reset_n        clock (rising edge), async active-low reset
//   req_valid[i]        level request, held until req_ack[i]
//   req_index[5i+:5]    Fibonacci index of requester i
//   req_ack[i]          one-cycle accept pulse (combinational, IDLE only)
//   rsp_valid/id/data   one-cycle response, tagged with requester id
//   rsp_ovf             index > 24, data truncated to 16 bits
//   rsp_err             engine timeout, data forced to 0
//   busy                FSM not in IDLE
//   eng_clear_n/index/start, eng_done/result   engine handshake
//
// After reset is released the block spends one extra IDLE cycle with the
// engine still cleared and no grants, so every output stays at its reset
// value until the first clock edge with reset_n high.
module fibo_job_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int TIMEOUT_CYC = 40
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [5*NUM_REQ-1:0] req_index,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic                 rsp_valid,
  output logic [ID_W-1:0]      rsp_id,
  output logic [15:0]          rsp_data,
  output logic                 rsp_ovf,
  output logic                 rsp_err,
  output logic                 busy,
  output logic                 eng_clear_n,
  output logic [4:0]           eng_index,
  output logic                 eng_start,
  input  logic                 eng_done,
  input  logic [15:0]          eng_result
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam int              CNT_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [1:0]       state_q, state_d;
  logic             armed_q;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [4:0]       idx_q, idx_d;
  logic [15:0]      data_q, data_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

`ifdef FIBO_LAST_RESULT_CACHE_EN
  logic             cache_vld_q, cache_vld_d;
  logic [4:0]       cache_idx_q, cache_idx_d;
  logic [15:0]      cache_data_q, cache_data_d;
`endif

  // Round-robin pick: lowest set bit at or above the pointer, else the
  // lowest set bit overall (wrap).
  logic             gnt_vld, hi_vld;
  logic [ID_W-1:0]  gnt_id, hi_id, lo_id, gnt_nxt;
  logic [4:0]       gnt_idx;
  logic             grant;

  always_comb begin
    gnt_vld = 1'b0;
    hi_vld  = 1'b0;
    hi_id   = '0;
    lo_id   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        gnt_vld = 1'b1;
        lo_id   = ID_W'(i);
        if (ID_W'(i) >= ptr_q) begin
          hi_vld = 1'b1;
          hi_id  = ID_W'(i);
        end
      end
    end
    gnt_id  = hi_vld ? hi_id : lo_id;
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == gnt_id) gnt_idx = req_index[i*5 +: 5];
    end
    gnt_nxt = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
  end

  assign grant   = (state_q == S_IDLE) && armed_q && gnt_vld;
  assign req_ack = grant ? (NUM_REQ'(1) << gnt_id) : '0;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    idx_d   = idx_q;
    data_d  = data_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
`ifdef FIBO_LAST_RESULT_CACHE_EN
    cache_vld_d  = cache_vld_q;
    cache_idx_d  = cache_idx_q;
    cache_data_d = cache_data_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (grant) begin
          id_d  = gnt_id;
          idx_d = gnt_idx;
          ptr_d = gnt_nxt;
          err_d = 1'b0;
          cnt_d = '0;
          if (gnt_idx < 5'd2) begin
            data_d  = {15'd0, gnt_idx[0]};
            state_d = S_RESP;
          end
`ifdef FIBO_LAST_RESULT_CACHE_EN
          else if (cache_vld_q && (cache_idx_q == gnt_idx)) begin
            data_d  = cache_data_q;
            state_d = S_RESP;
          end
`endif
          else begin
            state_d = S_CLEAR;
          end
        end
      end
      S_CLEAR: begin
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        // done has priority over a timeout landing in the same cycle
        if (eng_done) begin
          data_d  = eng_result;
          err_d   = 1'b0;
          state_d = S_RESP;
`ifdef FIBO_LAST_RESULT_CACHE_EN
          cache_vld_d  = 1'b1;
          cache_idx_d  = idx_q;
          cache_data_d = eng_result;
`endif
        end else if (cnt_q == CNT_LAST) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      armed_q <= 1'b0;
      ptr_q   <= '0;
      id_q    <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef FIBO_LAST_RESULT_CACHE_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cache_vld_q  <= 1'b0;
      cache_idx_q  <= '0;
      cache_data_q <= '0;
    end else begin
      cache_vld_q  <= cache_vld_d;
      cache_idx_q  <= cache_idx_d;
      cache_data_q <= cache_data_d;
    end
  end
`endif

  // Outputs decode straight from registers; armed_q keeps the engine
  // cleared until the first clock after reset.
  assign busy        = (state_q != S_IDLE);
  assign eng_clear_n = armed_q && ((state_q == S_IDLE) || (state_q == S_RUN));
  assign eng_start   = (state_q == S_RUN);
  assign eng_index   = idx_q;
  assign rsp_valid   = (state_q == S_RESP);
  assign rsp_id      = rsp_valid ? id_q : '0;
  assign rsp_data    = rsp_valid ? data_q : '0;
  assign rsp_ovf     = rsp_valid && (idx_q > 5'd24);
  assign rsp_err     = rsp_valid && err_q;

endmodule

// File: tb/tb_fibo_job_arbiter.sv
module tb_fibo_job_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int TO      = 40;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req_valid;
  logic [5*NUM_REQ-1:0] req_index;
  logic [NUM_REQ-1:0]   req_ack;
  logic                 rsp_valid, rsp_ovf, rsp_err, busy;
  logic [ID_W-1:0]      rsp_id;
  logic [15:0]          rsp_data;
  logic                 eng_clear_n, eng_start, eng_done;
  logic [4:0]           eng_index;
  logic [15:0]          eng_result;
  logic                 eng_dead;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fibo_job_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset_n(rst_n),
    .req_valid(req_valid), .req_index(req_index), .req_ack(req_ack),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_ovf(rsp_ovf), .rsp_err(rsp_err), .busy(busy),
    .eng_clear_n(eng_clear_n), .eng_index(eng_index), .eng_start(eng_start),
    .eng_done(eng_done), .eng_result(eng_result)
  );

  function automatic logic [15:0] fib16(input int n);
    int a, b, t;
    a = 0; b = 1;
    for (int i = 0; i < n; i++) begin
      t = (a + b) % 65536; a = b; b = t;
    end
    return a[15:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d @%0t", nm, act, exp, $time);
    end
  endtask

  // Compliant engine: count restarts at 2 on clear, +1 per start cycle,
  // done while start is high and the count equals the target index.
  int          e_k;
  logic [4:0]  e_tgt;
  always @(posedge clk) begin
    if (!eng_clear_n) begin
      e_k   <= 2;
      e_tgt <= eng_index;
    end else if (eng_start && e_k < int'(e_tgt)) begin
      e_k <= e_k + 1;
    end
  end
  assign eng_done   = eng_start && (e_k == int'(e_tgt)) && !eng_dead;
  assign eng_result = fib16(e_k);

  // Transaction-level model: job timing from the latency rules, grant
  // order from a round-robin pointer, data from fib16.
  int  cyc = 0, ack_c, rsp_c, m_ptr, m_id, m_n, g, j;
  bit  m_free = 1, m_armed = 0, m_eng, m_err, done_now, chk_idx, found, hit, c_vld = 0;
  int  c_idx;
  logic [15:0] m_data;
  logic [NUM_REQ-1:0] e_ack;
  logic e_rv, e_ovf, e_err, e_busy, e_start, e_clr;
  logic [ID_W-1:0] e_id;
  logic [15:0] e_d;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_free = 1; m_ptr = 0; m_armed = 0; c_vld = 0;
      chk("rst_req_ack", 32'(req_ack), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_eng_start", 32'(eng_start), 0);
      chk("rst_eng_clear_n", 32'(eng_clear_n), 0);
      chk("rst_eng_index", 32'(eng_index), 0);
    end else begin
      cyc++;
      e_ack = '0; e_rv = 0; e_id = '0; e_d = '0; e_ovf = 0; e_err = 0; e_start = 0;
      e_busy = !m_free; e_clr = m_armed; done_now = 0; chk_idx = 0;
      if (!m_free) begin
        if (cyc == rsp_c) begin
          e_rv = 1; e_id = ID_W'(m_id); e_d = m_data; e_ovf = (m_n > 24); e_err = m_err;
          e_clr = 0; done_now = 1;
        end else if (m_eng) begin
          chk_idx = 1;
          if (cyc == ack_c + 1) e_clr = 0;
          else e_start = 1;
        end
      end else if (m_armed && req_valid != '0) begin
        found = 0; g = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
          j = (m_ptr + k) % NUM_REQ;
          if (!found && req_valid[j]) begin found = 1; g = j; end
        end
        e_ack[g] = 1'b1;
        m_ptr = (g + 1) % NUM_REQ;
        m_id  = g;
        m_n   = int'(req_index[g*5 +: 5]);
        hit   = 0;
`ifdef FIBO_LAST_RESULT_CACHE_EN
        hit = c_vld && (c_idx == m_n) && (m_n >= 2);
`endif
        m_eng  = (m_n >= 2) && !hit;
        m_err  = m_eng && eng_dead;
        m_data = m_err ? 16'd0 : fib16(m_n);
        ack_c  = cyc;
        rsp_c  = cyc + (!m_eng ? 1 : (m_err ? 2 + TO : m_n + 1));
        if (m_eng && !m_err) begin c_vld = 1; c_idx = m_n; end
        m_free = 0;
      end
      chk("req_ack", 32'(req_ack), 32'(e_ack));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
      chk("rsp_id", 32'(rsp_id), 32'(e_id));
      chk("rsp_data", 32'(rsp_data), 32'(e_d));
      chk("rsp_ovf", 32'(rsp_ovf), 32'(e_ovf));
      chk("rsp_err", 32'(rsp_err), 32'(e_err));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("eng_start", 32'(eng_start), 32'(e_start));
      chk("eng_clear_n", 32'(eng_clear_n), 32'(e_clr));
      if (chk_idx) chk("eng_index", 32'(eng_index), 32'(m_n));
      if (done_now) m_free = 1;
      m_armed = 1;
    end
  end

  // Stimulus side: snapshots at negedge, requesters drop valid after ack.
  logic [NUM_REQ-1:0] s_ack;
  logic s_rv, s_ovf, s_err;
  logic [ID_W-1:0] s_id;
  logic [15:0] s_d;
  int tcyc = 0, ack_t = 0, rsp_t = 0, n_start = 0;

  task automatic tick();
    @(negedge clk);
    s_ack = req_ack; s_rv = rsp_valid; s_id = rsp_id; s_d = rsp_data;
    s_ovf = rsp_ovf; s_err = rsp_err;
    if (eng_start) n_start++;
    if (|req_ack) ack_t = tcyc;
    if (rsp_valid) rsp_t = tcyc;
    tcyc++;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~s_ack;
  endtask

  task automatic issue(input int r, input int n);
    req_index[r*5 +: 5] = 5'(n);
    req_valid[r] = 1'b1;
  endtask

  task automatic wait_rsp(input string nm);
    bit got;
    got = 0;
    for (int t = 0; t < 200 && !got; t++) begin
      tick();
      if (s_rv) got = 1;
    end
    chk({nm, "_seen"}, 32'(got), 1);
  endtask

  int t2_id[4];
  logic [15:0] t2_d[4];
  int ids3[3];
  bit got_ack;

  initial begin
    rst_n = 1'b0; req_valid = '0; req_index = '0; eng_dead = 1'b0;
    repeat (3) tick();
    chk("reset_clear_n", 32'(eng_clear_n), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    rst_n = 1'b1;
    repeat (2) tick();

    chk("pin_fib10", 32'(fib16(10)), 55);
    chk("pin_fib24", 32'(fib16(24)), 46368);
    chk("pin_fib25", 32'(fib16(25)), 9489);

    // single job, index 10
    n_start = 0; issue(0, 10); wait_rsp("t1");
    chk("t1_id", 32'(s_id), 0);
    chk("t1_data", 32'(s_d), 55);
    chk("t1_ovf", 32'(s_ovf), 0);
    chk("t1_err", 32'(s_err), 0);
    chk("t1_latency", 32'(rsp_t - ack_t), 11);
    chk("t1_run_cycles", 32'(n_start), 9);

    // move the pointer back to 0
    issue(3, 3); wait_rsp("park");
    chk("park_data", 32'(s_d), 2);

    // all four requesting
    issue(0, 2); issue(1, 5); issue(2, 12); issue(3, 24);
    for (int k = 0; k < 4; k++) begin
      wait_rsp("t2");
      t2_id[k] = int'(s_id); t2_d[k] = s_d;
    end
    chk("t2_id0", 32'(t2_id[0]), 0); chk("t2_d0", 32'(t2_d[0]), 1);
    chk("t2_id1", 32'(t2_id[1]), 1); chk("t2_d1", 32'(t2_d[1]), 5);
    chk("t2_id2", 32'(t2_id[2]), 2); chk("t2_d2", 32'(t2_d[2]), 144);
    chk("t2_id3", 32'(t2_id[3]), 3); chk("t2_d3", 32'(t2_d[3]), 46368);

    // requester 0 re-asserts right after its ack; 1 must go first
    issue(0, 2); issue(1, 3);
    got_ack = 0;
    for (int t = 0; t < 20 && !got_ack; t++) begin
      tick();
      if (s_ack[0]) got_ack = 1;
    end
    chk("reassert_ack_seen", 32'(got_ack), 1);
    issue(0, 4);
    for (int k = 0; k < 3; k++) begin
      wait_rsp("reassert");
      ids3[k] = int'(s_id);
    end
    chk("reassert_id0", 32'(ids3[0]), 0);
    chk("reassert_id1", 32'(ids3[1]), 1);
    chk("reassert_id2", 32'(ids3[2]), 0);
    chk("reassert_d2", 32'(s_d), 3);

    // local indices 0 and 1 on requester 2
    n_start = 0;
    issue(2, 0); wait_rsp("idx0");
    chk("idx0_data", 32'(s_d), 0);
    chk("idx0_latency", 32'(rsp_t - ack_t), 1);
    issue(2, 1); wait_rsp("idx1");
    chk("idx1_data", 32'(s_d), 1);
    chk("idx1_latency", 32'(rsp_t - ack_t), 1);
    chk("idx01_no_start", 32'(n_start), 0);

    // overflow index 25
    issue(1, 25); wait_rsp("ovf");
    chk("ovf_data", 32'(s_d), 9489);
    chk("ovf_flag", 32'(s_ovf), 1);

    // dead engine -> timeout, then a normal job
    eng_dead = 1'b1; n_start = 0;
    issue(0, 7); wait_rsp("tmo");
    chk("tmo_err", 32'(s_err), 1);
    chk("tmo_data", 32'(s_d), 0);
    chk("tmo_run_cycles", 32'(n_start), TO);
    chk("tmo_latency", 32'(rsp_t - ack_t), 2 + TO);
    eng_dead = 1'b0;
    issue(0, 4); wait_rsp("after_tmo");
    chk("after_tmo_data", 32'(s_d), 3);
    chk("after_tmo_err", 32'(s_err), 0);

    // same index twice
    issue(1, 10); wait_rsp("rep1");
    chk("rep1_data", 32'(s_d), 55);
    n_start = 0;
    issue(1, 10); wait_rsp("rep2");
    chk("rep2_data", 32'(s_d), 55);
`ifdef FIBO_LAST_RESULT_CACHE_EN
    chk("rep2_latency", 32'(rsp_t - ack_t), 1);
    chk("rep2_run_cycles", 32'(n_start), 0);
`else
    chk("rep2_latency", 32'(rsp_t - ack_t), 11);
    chk("rep2_run_cycles", 32'(n_start), 9);
`endif

    // reset in the middle of RUN
    issue(2, 20);
    repeat (6) tick();
    chk("midrun_start", 32'(eng_start), 1);
    #2;
    rst_n = 1'b0; req_valid = '0;
    #1;
    chk("async_clear_n", 32'(eng_clear_n), 0);
    chk("async_start", 32'(eng_start), 0);
    chk("async_busy", 32'(busy), 0);
    chk("async_rsp_valid", 32'(rsp_valid), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    n_start = 0;
    issue(2, 10); wait_rsp("post_rst");
    chk("post_rst_data", 32'(s_d), 55);
    chk("post_rst_run_cycles", 32'(n_start), 9);
    chk("post_rst_latency", 32'(rsp_t - ack_t), 11);

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
